key_dispatch: RTL and testbench

KEY_DISPATCH -- requirements
Module: key_dispatch

---
 rtl/key_dispatch.sv | 186 ++++++++++++++++++
 tb/tb_key_dispatch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_dispatch.sv
// key_dispatch: hands out fixed-size key chunks to arcfour search cores and gathers the search outcome.
// Build option KEY_DISPATCH_ROUND_ROBIN_EN selects rotating arbitration; default is fixed lowest-index priority.
module key_dispatch #(
  parameter int NUM_CORES = 51,
  parameter int LOG_NUM_CORES = 8,
  parameter int KEY_WIDTH = 24,
  parameter int CHUNK_LOG = 10,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX = 24'hffffff
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_success,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic [NUM_CORES-1:0]           grant,
  output logic [KEY_WIDTH-1:0]           grant_base,
  output logic [KEY_WIDTH-1:0]           grant_limit,
  output logic                           kill,
  output logic                           found,
  output logic                           exhausted,
  output logic                           busy,
  output logic [LOG_NUM_CORES-1:0]      found_core,
  output logic [KEY_WIDTH-1:0]           found_key
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DISPATCH  = 3'd1;
  localparam logic [2:0] ST_DRAIN     = 3'd2;
  localparam logic [2:0] ST_FOUND     = 3'd3;
  localparam logic [2:0] ST_EXHAUSTED = 3'd4;

  // Key arithmetic carries one extra bit so stepping past KEY_MAX never wraps to zero.
  localparam logic [KEY_WIDTH:0] CHUNK_SPAN  = ~({(KEY_WIDTH+1){1'b1}} << CHUNK_LOG);
  localparam logic [KEY_WIDTH:0] CHUNK_SIZE  = {{KEY_WIDTH{1'b0}}, 1'b1} << CHUNK_LOG;
  localparam logic [KEY_WIDTH:0] KEY_MAX_EXT = {1'b0, KEY_MAX};

  logic [2:0]               state;
  logic [KEY_WIDTH:0]       next_base;
  logic [KEY_WIDTH:0]       base_after;
  logic [KEY_WIDTH:0]       chunk_last;
  logic [KEY_WIDTH-1:0]     limit_value;
  logic [NUM_CORES-1:0]     outstanding;
  logic [NUM_CORES-1:0]     live;
  logic [NUM_CORES-1:0]     eligible;
  logic [NUM_CORES-1:0]     arb_onehot;
  logic                     arb_valid;
  logic                     success_any;
  logic                     grant_fire;
  logic [LOG_NUM_CORES-1:0] succ_idx;
  logic [KEY_WIDTH-1:0]     succ_key;

  // A core finishing this cycle is free to take a new chunk on the same edge.
  assign live        = outstanding & ~core_done;
  assign eligible    = core_req & ~live;
  assign success_any = |core_success;
  assign grant_fire  = (state == ST_DISPATCH) && !success_any && !abort && arb_valid;
  assign busy        = (state == ST_DISPATCH) || (state == ST_DRAIN);
  assign base_after  = next_base + CHUNK_SIZE;
  assign chunk_last  = next_base + CHUNK_SPAN;
  assign limit_value = (chunk_last > KEY_MAX_EXT) ? KEY_MAX : chunk_last[KEY_WIDTH-1:0];

  always_comb begin
    succ_idx = '0;
    succ_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_success[i]) begin
        succ_idx = LOG_NUM_CORES'(i);
        succ_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

`ifdef KEY_DISPATCH_ROUND_ROBIN_EN
  logic [LOG_NUM_CORES-1:0] rr_ptr;
  logic [LOG_NUM_CORES-1:0] arb_idx;
  logic [NUM_CORES-1:0]     rr_rot;
  logic [NUM_CORES-1:0]     rr_hot;
  int                       rr_pos;

  // Rotate requests so the pointer sits at bit 0, pick the lowest, then rotate the winner back.
  always_comb begin
    rr_rot = NUM_CORES'({eligible, eligible} >> rr_ptr);
    rr_hot = '0;
    rr_pos = 0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rr_rot[i]) begin
        rr_hot    = '0;
        rr_hot[i] = 1'b1;
        rr_pos    = i;
      end
    end
    rr_pos = rr_pos + int'(rr_ptr);
    if (rr_pos >= NUM_CORES) rr_pos = rr_pos - NUM_CORES;
    arb_idx    = LOG_NUM_CORES'(rr_pos);
    arb_onehot = NUM_CORES'(({rr_hot, rr_hot} << rr_ptr) >> NUM_CORES);
    arb_valid  = |eligible;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (arb_idx == LOG_NUM_CORES'(NUM_CORES - 1)) ? '0 : arb_idx + LOG_NUM_CORES'(1);
    end
  end
`else
  always_comb begin
    arb_onehot = '0;
    arb_valid  = |eligible;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        arb_onehot    = '0;
        arb_onehot[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      next_base   <= '0;
      outstanding <= '0;
      grant       <= '0;
      grant_base  <= '0;
      grant_limit <= '0;
      kill        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_core  <= '0;
      found_key   <= '0;
    end else begin
      grant <= '0;
      kill  <= 1'b0;
      case (state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            state       <= ST_DISPATCH;
            next_base   <= '0;
            outstanding <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_core  <= '0;
            found_key   <= '0;
          end
        end
        ST_DISPATCH, ST_DRAIN: begin
          // Success outranks abort, completion and any grant in the same cycle.
          if (success_any) begin
            state       <= ST_FOUND;
            found       <= 1'b1;
            found_core  <= succ_idx;
            found_key   <= succ_key;
            kill        <= 1'b1;
            outstanding <= '0;
          end else if (abort) begin
            state       <= ST_IDLE;
            kill        <= 1'b1;
            outstanding <= '0;
          end else if (state == ST_DRAIN) begin
            outstanding <= live;
            if (outstanding == '0) begin
              state     <= ST_EXHAUSTED;
              exhausted <= 1'b1;
              kill      <= 1'b1;
            end
          end else begin
            outstanding <= live | (grant_fire ? arb_onehot : '0);
            if (grant_fire) begin
              grant       <= arb_onehot;
              grant_base  <= next_base[KEY_WIDTH-1:0];
              grant_limit <= limit_value;
              next_base   <= base_after;
              if (base_after > KEY_MAX_EXT) state <= ST_DRAIN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_dispatch.sv
// tb_key_dispatch: two key_dispatch instances (KEY_MAX 15 and 13) driven together and checked
// every cycle against a behavioural search model, plus directed scenario checks.
module tb_key_dispatch;

  localparam int NC = 4;
  localparam int KW = 16;
  localparam int CL = 2;
  localparam int CHUNK = 1 << CL;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [NC-1:0] core_req, core_done, core_success;
  logic [KW-1:0] keys [NC];
  logic [NC*KW-1:0] core_key;

  logic [NC-1:0] grant_o [2];
  logic [KW-1:0] base_o [2];
  logic [KW-1:0] limit_o [2];
  logic          kill_o [2];
  logic          found_o [2];
  logic          exh_o [2];
  logic          busy_o [2];
  logic [1:0]    fcore_o [2];
  logic [KW-1:0] fkey_o [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model: one search per instance, described by "searching", next key and cores owning chunks.
  int       kmax [2] = '{15, 13};
  bit       m_active [2];
  int       m_next [2];
  bit [3:0] m_out [2];
  bit       m_found [2];
  bit       m_exh [2];
  int       m_fcore [2];
  int       m_fkey [2];
  bit [3:0] m_grant [2];
  int       m_base [2];
  int       m_limit [2];
  bit       m_kill [2];
  bit       m_rst [2];
  int       m_ptr [2];

  always #5 clk = ~clk;

  always_comb begin
    core_key = '0;
    for (int i = 0; i < NC; i++) core_key[i*KW +: KW] = keys[i];
  end

  key_dispatch #(.NUM_CORES(NC), .LOG_NUM_CORES(2), .KEY_WIDTH(KW), .CHUNK_LOG(CL), .KEY_MAX(16'd15)) dut15 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .core_req(core_req), .core_done(core_done), .core_success(core_success), .core_key(core_key),
    .grant(grant_o[0]), .grant_base(base_o[0]), .grant_limit(limit_o[0]), .kill(kill_o[0]),
    .found(found_o[0]), .exhausted(exh_o[0]), .busy(busy_o[0]),
    .found_core(fcore_o[0]), .found_key(fkey_o[0])
  );

  key_dispatch #(.NUM_CORES(NC), .LOG_NUM_CORES(2), .KEY_WIDTH(KW), .CHUNK_LOG(CL), .KEY_MAX(16'd13)) dut13 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .core_req(core_req), .core_done(core_done), .core_success(core_success), .core_key(core_key),
    .grant(grant_o[1]), .grant_base(base_o[1]), .grant_limit(limit_o[1]), .kill(kill_o[1]),
    .found(found_o[1]), .exhausted(exh_o[1]), .busy(busy_o[1]),
    .found_core(fcore_o[1]), .found_key(fkey_o[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input int n);
    bit [3:0] freed;
    bit [3:0] elig;
    int win;
    m_grant[n] = '0;
    m_kill[n]  = 1'b0;
    m_rst[n]   = reset;
    if (reset) begin
      m_active[n] = 0; m_next[n] = 0; m_out[n] = '0; m_found[n] = 0; m_exh[n] = 0;
      m_fcore[n] = 0; m_fkey[n] = 0; m_base[n] = 0; m_limit[n] = 0; m_ptr[n] = 0;
      return;
    end
    if (!m_active[n]) begin
      if (start) begin
        m_active[n] = 1; m_next[n] = 0; m_out[n] = '0; m_found[n] = 0; m_exh[n] = 0;
        m_fcore[n] = 0; m_fkey[n] = 0;
      end
    end else if (core_success != 0) begin
      win = -1;
      for (int i = 0; i < NC; i++) if (core_success[i] && win < 0) win = i;
      m_found[n] = 1; m_fcore[n] = win; m_fkey[n] = int'(keys[win]);
      m_active[n] = 0; m_kill[n] = 1;
    end else if (abort) begin
      m_active[n] = 0; m_kill[n] = 1;
    end else if (m_next[n] > kmax[n]) begin
      if (m_out[n] == 0) begin
        m_exh[n] = 1; m_active[n] = 0; m_kill[n] = 1;
      end else begin
        m_out[n] = m_out[n] & ~core_done;
      end
    end else begin
      freed    = m_out[n] & ~core_done;
      elig     = core_req & ~freed;
      m_out[n] = freed;
      if (elig != 0) begin
        win = -1;
`ifdef KEY_DISPATCH_ROUND_ROBIN_EN
        for (int k = 0; k < NC; k++) if (elig[(m_ptr[n] + k) % NC] && win < 0) win = (m_ptr[n] + k) % NC;
`else
        for (int k = 0; k < NC; k++) if (elig[k] && win < 0) win = k;
`endif
        m_grant[n][win] = 1'b1;
        m_out[n][win]   = 1'b1;
        m_base[n]       = m_next[n];
        m_limit[n]      = (m_next[n] + CHUNK - 1 > kmax[n]) ? kmax[n] : m_next[n] + CHUNK - 1;
        m_next[n]       = m_next[n] + CHUNK;
        m_ptr[n]        = (win + 1) % NC;
      end
    end
  endtask

  task automatic compareAll(input int n);
    checkOutput($sformatf("grant%0d", n), 32'(grant_o[n]), 32'(m_grant[n]));
    if (m_grant[n] != 0 || m_rst[n]) begin
      checkOutput($sformatf("grant_base%0d", n), 32'(base_o[n]), m_base[n]);
      checkOutput($sformatf("grant_limit%0d", n), 32'(limit_o[n]), m_limit[n]);
    end
    checkOutput($sformatf("kill%0d", n), 32'(kill_o[n]), 32'(m_kill[n]));
    checkOutput($sformatf("found%0d", n), 32'(found_o[n]), 32'(m_found[n]));
    checkOutput($sformatf("exhausted%0d", n), 32'(exh_o[n]), 32'(m_exh[n]));
    checkOutput($sformatf("busy%0d", n), 32'(busy_o[n]), 32'(m_active[n]));
    checkOutput($sformatf("found_core%0d", n), 32'(fcore_o[n]), m_fcore[n]);
    checkOutput($sformatf("found_key%0d", n), 32'(fkey_o[n]), m_fkey[n]);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic ab,
                               input logic [NC-1:0] req, input logic [NC-1:0] done,
                               input logic [NC-1:0] succ);
    reset = rst; start = st; abort = ab;
    core_req = req; core_done = done; core_success = succ;
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    @(negedge clk);
    compareAll(0);
    compareAll(1);
  endtask

  initial begin
    int q15 [$];
    int q13 [$];
    int last_limit13;
    int kills15;
    logic [NC-1:0] seq [$];

    for (int i = 0; i < NC; i++) keys[i] = 16'($urandom);
    applyStimulus(1, 0, 0, '0, '0, '0);
    applyStimulus(1, 1, 1, 4'hF, 4'hF, 4'hF);

    // Full search with every core requesting and completing each cycle.
    applyStimulus(0, 1, 0, '0, '0, '0);
    kills15 = 0;
    last_limit13 = -1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 0, 4'hF, 4'hF, '0);
      if (grant_o[0] != 0) q15.push_back(int'(base_o[0]));
      if (grant_o[1] != 0) begin
        q13.push_back(int'(base_o[1]));
        last_limit13 = int'(limit_o[1]);
      end
      if (kill_o[0]) kills15++;
    end
    checkOutput("seq15_count", q15.size(), 4);
    for (int i = 0; i < q15.size() && i < 4; i++) checkOutput($sformatf("seq15_base%0d", i), q15[i], i * 4);
    checkOutput("exhausted15", 32'(exh_o[0]), 1);
    checkOutput("kill15_pulses", kills15, 1);
    checkOutput("seq13_count", q13.size(), 4);
    if (q13.size() > 0) checkOutput("seq13_last_base", q13[q13.size()-1], 12);
    checkOutput("seq13_last_limit", last_limit13, 13);

    // Two cores succeed together; the lower index wins.
    applyStimulus(0, 1, 0, '0, '0, '0);
    keys[1] = 16'h00A5;
    keys[2] = 16'h1234;
    applyStimulus(0, 0, 0, '0, '0, 4'b0110);
    checkOutput("win_found", 32'(found_o[0]), 1);
    checkOutput("win_core", 32'(fcore_o[0]), 1);
    checkOutput("win_key", 32'(fkey_o[0]), 32'h00A5);
    checkOutput("win_kill", 32'(kill_o[0]), 1);
    applyStimulus(0, 0, 0, '0, '0, '0);
    checkOutput("win_kill_end", 32'(kill_o[0]), 0);
    checkOutput("win_hold", 32'(fkey_o[0]), 32'h00A5);

    // Cores 0 and 3 request continuously and complete immediately.
    applyStimulus(0, 1, 0, '0, '0, '0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 4'b1001, 4'b1001, '0);
      seq.push_back(grant_o[0]);
    end
    for (int i = 0; i < 4; i++) begin
`ifdef KEY_DISPATCH_ROUND_ROBIN_EN
      checkOutput($sformatf("arb_grant%0d", i), 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h8);
`else
      checkOutput($sformatf("arb_grant%0d", i), 32'(seq[i]), 32'h1);
`endif
    end
    applyStimulus(0, 0, 1, '0, '0, '0);

    // Abort after two grants, then restart from key 0.
    applyStimulus(0, 1, 0, '0, '0, '0);
    applyStimulus(0, 0, 0, 4'hF, '0, '0);
    applyStimulus(0, 0, 0, 4'hF, '0, '0);
    applyStimulus(0, 0, 1, '0, '0, '0);
    checkOutput("abort_kill", 32'(kill_o[0]), 1);
    checkOutput("abort_busy", 32'(busy_o[0]), 0);
    checkOutput("abort_found", 32'(found_o[0]), 0);
    checkOutput("abort_exh", 32'(exh_o[0]), 0);
    applyStimulus(0, 0, 0, '0, '0, '0);
    checkOutput("abort_kill_end", 32'(kill_o[0]), 0);
    applyStimulus(0, 1, 0, '0, '0, '0);
    applyStimulus(0, 0, 0, 4'hF, '0, '0);
    checkOutput("regrant_valid", 32'(grant_o[0] != 0), 1);
    checkOutput("regrant_base", 32'(base_o[0]), 0);

    // Run into the drain phase, then reset.
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 4'hF, '0, '0);
    checkOutput("drain_busy", 32'(busy_o[0]), 1);
    applyStimulus(1, 0, 0, 4'hF, 4'hF, '0);
    checkOutput("rst_grant", 32'(grant_o[0]), 0);
    checkOutput("rst_base", 32'(base_o[0]), 0);
    checkOutput("rst_limit", 32'(limit_o[0]), 0);
    checkOutput("rst_kill", 32'(kill_o[0]), 0);
    checkOutput("rst_busy", 32'(busy_o[0]), 0);
    checkOutput("rst_found", 32'(found_o[0]), 0);
    checkOutput("rst_exh", 32'(exh_o[0]), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NC; i++) keys[i] = 16'($urandom);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
                    4'($urandom), 4'($urandom),
                    ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
